// File: rtl/pipeline_control_ldst_arbiter_pkg.sv
// Shared definitions for the pipeline-control load/store arbiter: FSM state
// encodings, requester index constants, ORDER encodings, command payload
// struct and an index-width helper.
package pipeline_control_ldst_arbiter_pkg;

   localparam int unsigned ORDER_W  = 2;
   localparam int unsigned ASID_W   = 14;
   localparam int unsigned MMUMOD_W = 2;
   localparam int unsigned PDT_W    = 32;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   localparam int unsigned REQ_IDT = 0;
   localparam int unsigned REQ_EXC = 1;
   localparam int unsigned REQ_LSU = 2;

   localparam logic [ORDER_W-1:0] ORDER_BYTE = 2'b00;
   localparam logic [ORDER_W-1:0] ORDER_HALF = 2'b01;
   localparam logic [ORDER_W-1:0] ORDER_WORD = 2'b10;
   localparam logic [ORDER_W-1:0] ORDER_NONE = 2'b11;

   typedef struct packed {
      logic [ORDER_W-1:0]  order;
      logic                rw;
      logic [ASID_W-1:0]   asid;
      logic [MMUMOD_W-1:0] mmumod;
      logic [PDT_W-1:0]    pdt;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   data;
   } ldst_cmd_t;

   // Width of a requester index; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipeline_control_ldst_arb_pick.sv
// Combinational winner selection for the load/store arbiter.
// Macro MIST1032ISA_LDST_ARB_RR_EN: round-robin search starting at iPTR+1;
// otherwise fixed priority with index 0 highest (iPTR ignored).
// Ports: iREQ request vector, iPTR last winner, oWIN one-hot winner,
//        oIDX winner index (0 when nothing requested).
module pipeline_control_ldst_arb_pick #(
   parameter int unsigned P_REQ_N = 3,
   parameter int unsigned P_IDX_W = 2
) (
   input  logic [P_REQ_N-1:0] iREQ,
   input  logic [P_IDX_W-1:0] iPTR,
   output logic [P_REQ_N-1:0] oWIN,
   output logic [P_IDX_W-1:0] oIDX
);

   logic               found;
   logic [P_IDX_W-1:0] cand;

`ifdef MIST1032ISA_LDST_ARB_RR_EN
   // Rotate the search so the last winner is visited last.
   always_comb begin
      oWIN  = '0;
      oIDX  = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < P_REQ_N; k++) begin
         cand = P_IDX_W'((32'(iPTR) + 32'd1 + k) % P_REQ_N);
         if (!found && iREQ[cand]) begin
            found      = 1'b1;
            oWIN[cand] = 1'b1;
            oIDX       = cand;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^iPTR;

   // Lowest index wins.
   always_comb begin
      oWIN  = '0;
      oIDX  = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < P_REQ_N; k++) begin
         cand = P_IDX_W'(k);
         if (!found && iREQ[cand]) begin
            found      = 1'b1;
            oWIN[cand] = 1'b1;
            oIDX       = cand;
         end
      end
   end
`endif

endmodule

// File: rtl/pipeline_control_ldst_arbiter.sv
// Session arbiter sharing the single load/store port between the IDT reader
// (0), exception unit (1) and LSU (2). A requester owns the port while it
// holds USE; ownership moves only after all of its responses have returned.
// Macro MIST1032ISA_LDST_ARB_RR_EN selects round-robin grant (default fixed).
// Ports: iCLOCK/iRESET (async, high)/iRESET_SYNC; iREQ_* packed per-requester
// commands, oREQ_BUSY/oREQ_VALID/oREQ_DATA back to requesters; oLDST_* command
// downstream, iLDST_BUSY/iLDST_REQ/iLDST_DATA from downstream; oERR_UNEXP
// sticky flag for a response arriving with nothing outstanding.
module pipeline_control_ldst_arbiter
   import pipeline_control_ldst_arbiter_pkg::*;
#(
   parameter int unsigned P_REQ_N     = 3,
   parameter int unsigned P_OUTST_MAX = 4
) (
   input  logic                        iCLOCK,
   input  logic                        iRESET,
   input  logic                        iRESET_SYNC,
   input  logic [P_REQ_N-1:0]          iREQ_USE,
   input  logic [P_REQ_N-1:0]          iREQ_REQ,
   input  logic [P_REQ_N*ORDER_W-1:0]  iREQ_ORDER,
   input  logic [P_REQ_N-1:0]          iREQ_RW,
   input  logic [P_REQ_N*ASID_W-1:0]   iREQ_ASID,
   input  logic [P_REQ_N*MMUMOD_W-1:0] iREQ_MMUMOD,
   input  logic [P_REQ_N*PDT_W-1:0]    iREQ_PDT,
   input  logic [P_REQ_N*ADDR_W-1:0]   iREQ_ADDR,
   input  logic [P_REQ_N*DATA_W-1:0]   iREQ_DATA,
   output logic [P_REQ_N-1:0]          oREQ_BUSY,
   output logic [P_REQ_N-1:0]          oREQ_VALID,
   output logic [DATA_W-1:0]           oREQ_DATA,
   output logic                        oLDST_REQ,
   output logic [ORDER_W-1:0]          oLDST_ORDER,
   output logic                        oLDST_RW,
   output logic [ASID_W-1:0]           oLDST_ASID,
   output logic [MMUMOD_W-1:0]         oLDST_MMUMOD,
   output logic [PDT_W-1:0]            oLDST_PDT,
   output logic [ADDR_W-1:0]           oLDST_ADDR,
   output logic [DATA_W-1:0]           oLDST_DATA,
   input  logic                        iLDST_BUSY,
   input  logic                        iLDST_REQ,
   input  logic [DATA_W-1:0]           iLDST_DATA,
   output logic                        oERR_UNEXP
);

   localparam int unsigned IW = idx_w(P_REQ_N);
   localparam int unsigned CW = $clog2(P_OUTST_MAX + 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [IW-1:0]   pick_ptr, pick_idx;
   logic [P_REQ_N-1:0] pick_win;
   logic            grant, issue, resp_ok, cnt_full;
   ldst_cmd_t       cmd;

   pipeline_control_ldst_arb_pick #(
      .P_REQ_N (P_REQ_N),
      .P_IDX_W (IW)
   ) u_pick (
      .iREQ (iREQ_USE),
      .iPTR (pick_ptr),
      .oWIN (pick_win),
      .oIDX (pick_idx)
   );

   assign grant = |pick_win;

`ifdef MIST1032ISA_LDST_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;
   assign pick_ptr = ptr_q;
   assign ptr_d    = (state_q == ST_IDLE && grant) ? pick_idx : ptr_q;

   // Last-winner pointer for the round-robin search.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET)           ptr_q <= '0;
      else if (iRESET_SYNC) ptr_q <= '0;
      else                  ptr_q <= ptr_d;
   end
`else
   assign pick_ptr = '0;
`endif

   // Next-state, counter, routing and command mux.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      cmd        = '0;
      oREQ_BUSY  = '1;
      oREQ_VALID = '0;

      cnt_full = (cnt_q == CW'(P_OUTST_MAX));
      issue    = (state_q == ST_OWNED) && iREQ_REQ[owner_q] && !iLDST_BUSY && !cnt_full;
      // A response with nothing outstanding is flagged, never routed or counted.
      resp_ok  = iLDST_REQ && (cnt_q != '0);

      if (iLDST_REQ && (cnt_q == '0)) err_d = 1'b1;
      if (resp_ok) oREQ_VALID[owner_q] = 1'b1;

      if (issue && !resp_ok)      cnt_d = cnt_q + CW'(1);
      else if (!issue && resp_ok) cnt_d = cnt_q - CW'(1);

      if (state_q == ST_OWNED) begin
         oREQ_BUSY[owner_q] = iLDST_BUSY || cnt_full;
         cmd.order  = iREQ_ORDER[owner_q*ORDER_W +: ORDER_W];
         cmd.rw     = iREQ_RW[owner_q];
         cmd.asid   = iREQ_ASID[owner_q*ASID_W +: ASID_W];
         cmd.mmumod = iREQ_MMUMOD[owner_q*MMUMOD_W +: MMUMOD_W];
         cmd.pdt    = iREQ_PDT[owner_q*PDT_W +: PDT_W];
         cmd.addr   = iREQ_ADDR[owner_q*ADDR_W +: ADDR_W];
         cmd.data   = iREQ_DATA[owner_q*DATA_W +: DATA_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_OWNED;
               owner_d = pick_idx;
            end
         end
         ST_OWNED: begin
            // Release looks at the post-update count so a same-cycle issue
            // or arrival decides between IDLE and DRAIN correctly.
            if (!iREQ_USE[owner_q]) state_d = (cnt_d == '0) ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cnt_d == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q <= ST_IDLE;
         owner_q <= IW'(REQ_IDT);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else if (iRESET_SYNC) begin
         state_q <= ST_IDLE;
         owner_q <= IW'(REQ_IDT);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign oLDST_REQ    = issue;
   assign oLDST_ORDER  = cmd.order;
   assign oLDST_RW     = cmd.rw;
   assign oLDST_ASID   = cmd.asid;
   assign oLDST_MMUMOD = cmd.mmumod;
   assign oLDST_PDT    = cmd.pdt;
   assign oLDST_ADDR   = cmd.addr;
   assign oLDST_DATA   = cmd.data;
   assign oREQ_DATA    = iLDST_DATA;
   assign oERR_UNEXP   = err_q;

endmodule

// File: tb/tb_pipeline_control_ldst_arbiter.sv
// Self-checking bench for pipeline_control_ldst_arbiter: a cycle table for
// contention/backpressure/stray-response behaviour, an IDT read burst with a
// response scoreboard, sync-reset mid-drain, and grant ordering.
module tb_pipeline_control_ldst_arbiter;
   import pipeline_control_ldst_arbiter_pkg::*;

   localparam logic [31:0] IDTR = 32'h0004_0000;
   localparam logic [31:0] A0   = 32'hA000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst_sync;
   logic [2:0]  use_v, req_v, rw_v;
   logic [5:0]  order_v, mmu_v;
   logic [41:0] asid_v;
   logic [95:0] pdt_v, addr_v, data_v;
   logic        lbusy, lreq;
   logic [31:0] ldata;
   logic [2:0]  busy_o, valid_o;
   logic [31:0] rdata_o;
   logic        ldst_req_o, ldst_rw_o, err_o;
   logic [1:0]  ldst_order_o, ldst_mmu_o;
   logic [13:0] ldst_asid_o;
   logic [31:0] ldst_pdt_o, ldst_addr_o, ldst_data_o;

   pipeline_control_ldst_arbiter #(.P_REQ_N(3), .P_OUTST_MAX(4)) dut (
      .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(rst_sync),
      .iREQ_USE(use_v), .iREQ_REQ(req_v), .iREQ_ORDER(order_v), .iREQ_RW(rw_v),
      .iREQ_ASID(asid_v), .iREQ_MMUMOD(mmu_v), .iREQ_PDT(pdt_v),
      .iREQ_ADDR(addr_v), .iREQ_DATA(data_v),
      .oREQ_BUSY(busy_o), .oREQ_VALID(valid_o), .oREQ_DATA(rdata_o),
      .oLDST_REQ(ldst_req_o), .oLDST_ORDER(ldst_order_o), .oLDST_RW(ldst_rw_o),
      .oLDST_ASID(ldst_asid_o), .oLDST_MMUMOD(ldst_mmu_o), .oLDST_PDT(ldst_pdt_o),
      .oLDST_ADDR(ldst_addr_o), .oLDST_DATA(ldst_data_o),
      .iLDST_BUSY(lbusy), .iLDST_REQ(lreq), .iLDST_DATA(ldata),
      .oERR_UNEXP(err_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one cycle, sample combinational outputs mid-cycle, then advance.
   task automatic cyc(input string nm, input logic [2:0] u, input logic [2:0] r,
                      input logic lb, input logic lr, input logic [2:0] eb,
                      input logic [2:0] ev, input logic el, input logic ee,
                      input logic ca, input logic [31:0] ea);
      use_v = u; req_v = r; lbusy = lb; lreq = lr;
      @(negedge clk);
      chk({nm, "_busy"},  32'(busy_o),     32'(eb));
      chk({nm, "_valid"}, 32'(valid_o),    32'(ev));
      chk({nm, "_lreq"},  32'(ldst_req_o), 32'(el));
      chk({nm, "_err"},   32'(err_o),      32'(ee));
      if (ca) chk({nm, "_addr"}, ldst_addr_o, ea);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  u, r;
      logic        lb, lr;
      logic [2:0]  eb, ev;
      logic        el, ee;
      logic [31:0] ea;
   } vec_t;

   vec_t        tbl[26];
   logic [31:0] sbq[$];
   int          exp_own[4];
   int          issued, answered;
   logic        p1v, p2v, nv;
   logic [31:0] p1d, p2d, nd, a;
   logic [2:0]  m;

   initial begin
      rst = 1'b1; rst_sync = 1'b0;
      use_v = '0; req_v = '0; lbusy = 1'b0; lreq = 1'b0; ldata = '0;
      order_v = {3{ORDER_WORD}}; rw_v = '0; asid_v = '0; mmu_v = '0; pdt_v = '0;
      addr_v = {A0 + 32'd2, A0 + 32'd1, A0};
      data_v = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

      //            use     req     lb    lr    busy    valid   lreq  err   addr
      tbl[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{3'b110, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{3'b110, 3'b010, 1'b0, 1'b0, 3'b101, 3'b000, 1'b1, 1'b0, A0 + 32'd1};
      tbl[3]  = '{3'b110, 3'b010, 1'b0, 1'b0, 3'b101, 3'b000, 1'b1, 1'b0, A0 + 32'd1};
      tbl[4]  = '{3'b100, 3'b000, 1'b0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, A0 + 32'd1};
      tbl[5]  = '{3'b100, 3'b000, 1'b0, 1'b1, 3'b111, 3'b010, 1'b0, 1'b0, 32'h0};
      tbl[6]  = '{3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{3'b100, 3'b000, 1'b0, 1'b1, 3'b111, 3'b010, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
      for (int i = 9; i <= 12; i++)
         tbl[i] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1, 1'b0, A0 + 32'd2};
      tbl[13] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, A0 + 32'd2};
      tbl[14] = '{3'b100, 3'b100, 1'b0, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0, A0 + 32'd2};
      tbl[15] = '{3'b100, 3'b100, 1'b0, 1'b1, 3'b011, 3'b100, 1'b1, 1'b0, A0 + 32'd2};
      tbl[16] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1, 1'b0, A0 + 32'd2};
      tbl[17] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, A0 + 32'd2};
      tbl[18] = '{3'b100, 3'b100, 1'b1, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0, A0 + 32'd2};
      tbl[19] = '{3'b100, 3'b100, 1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, A0 + 32'd2};
      tbl[20] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b011, 3'b100, 1'b0, 1'b0, A0 + 32'd2};
      tbl[21] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0, 32'h0};
      tbl[22] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0, 32'h0};
      tbl[23] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
      tbl[24] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0};
      tbl[25] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0};

`ifdef MIST1032ISA_LDST_ARB_RR_EN
      exp_own = '{0, 1, 2, 0};
`else
      exp_own = '{0, 0, 0, 0};
`endif

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Contention, drain, backpressure and stray response.
      for (int i = 0; i < 26; i++)
         cyc($sformatf("row%0d", i), tbl[i].u, tbl[i].r, tbl[i].lb, tbl[i].lr,
             tbl[i].eb, tbl[i].ev, tbl[i].el, tbl[i].ee, 1'b1, tbl[i].ea);

      // Async reset clears the sticky error immediately.
      lreq = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("async_rst_err", 32'(err_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'h7);
      @(posedge clk);
      #1 rst = 1'b0;

      // IDT reader burst: 65 word reads, responses two cycles after issue.
      use_v = 3'b001; req_v = '0;
      @(posedge clk);
      #1;
      issued = 0; answered = 0; p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0;
      for (int c = 0; c < 400 && answered < 65; c++) begin
         a = IDTR + 32'(issued) * 32'd8;
         req_v = {2'b00, issued < 65};
         addr_v[31:0] = a;
         lreq = p2v; ldata = p2d;
         @(negedge clk);
         nv = 1'b0; nd = '0;
         if (ldst_req_o) begin
            chk($sformatf("idt_addr%0d", issued), ldst_addr_o, a);
            nd = a ^ 32'hC0DE_0000;
            nv = 1'b1;
            sbq.push_back(nd);
            issued++;
         end
         if (valid_o != 3'b000) begin
            if (sbq.size() == 0 || valid_o != 3'b001) chk("idt_valid", 32'(valid_o), 32'd0);
            else chk("idt_data", rdata_o, sbq.pop_front());
            answered++;
         end
         @(posedge clk);
         p2v = p1v; p2d = p1d; p1v = nv; p1d = nd;
         #1;
      end
      chk("idt_issued", 32'(issued), 32'd65);
      chk("idt_answered", 32'(answered), 32'd65);
      chk("idt_sb_empty", 32'(sbq.size()), 32'd0);
      lreq = 1'b0;
      cyc("idt_release", 3'b000, 3'b000, 1'b0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      cyc("idt_idle",    3'b010, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);

      // Sync reset during DRAIN, then stray response and sync clear of error.
      cyc("exc_iss0", 3'b010, 3'b010, 1'b0, 1'b0, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0, '0);
      cyc("exc_iss1", 3'b010, 3'b010, 1'b0, 1'b0, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0, '0);
      cyc("exc_drop", 3'b000, 3'b000, 1'b0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      rst_sync = 1'b1;
      cyc("drain_sync", 3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      rst_sync = 1'b0;
      cyc("post_sync_stray", 3'b100, 3'b000, 1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      cyc("post_sync_grant", 3'b000, 3'b000, 1'b0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 1'b0, '0);
      rst_sync = 1'b1;
      cyc("err_hold", 3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, '0);
      rst_sync = 1'b0;
      cyc("err_sync_clr", 3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);

      // Grant order with all USE held and sessions released in turn.
      cyc("gpre_idle", 3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      cyc("gpre_own",  3'b000, 3'b000, 1'b0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, '0);
      for (int s = 0; s < 4; s++) begin
         m = 3'b111 ^ (3'b001 << exp_own[s]);
         cyc($sformatf("g%0d_idle", s), 3'b111, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000,
             1'b0, 1'b0, 1'b0, '0);
         cyc($sformatf("g%0d_own", s), m, 3'b000, 1'b0, 1'b0, m, 3'b000,
             1'b0, 1'b0, 1'b0, '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
